// File: rtl/im_pkg.sv
// Shared types for the IM register-file sequencer: opcodes, FSM states,
// datapath widths and small decode helpers.
package im_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 8;
    localparam int OP_W   = 3;
    localparam int CNT_W  = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'd0,
        OP_LDI  = 3'd1,
        OP_MOV  = 3'd2,
        OP_ALU  = 3'd3,
        OP_ALUF = 3'd4
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_LDI  = 4'd1,
        ST_MOV  = 4'd2,
        ST_RDA  = 4'd3,
        ST_RDB  = 4'd4,
        ST_WAIT = 4'd5,
        ST_WRC  = 4'd6,
        ST_WRF  = 4'd7,
        ST_NOPX = 4'd8
    } state_e;

    // Opcodes 5..7 are outside the defined instruction set.
    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return (op >= 3'd5);
    endfunction

    // First bus state entered after accepting an instruction.
    function automatic state_e op_to_state(input logic [OP_W-1:0] op);
        state_e st;
        case (op)
            OP_LDI:  st = ST_LDI;
            OP_MOV:  st = ST_MOV;
            OP_ALU:  st = ST_RDA;
            OP_ALUF: st = ST_RDA;
            default: st = ST_NOPX;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/im_sequencer.sv
// Bus-master sequencer for the 32x8 IM register file. Accepts one
// register-transfer instruction at a time and expands it into timed
// read/write-select, tristate-enable and operand-capture strobes. All
// outputs are registered and decoded from the next state, so each output
// set lines up with the cycle the FSM spends in that state and nothing
// on in_* reaches an output combinationally.
module im_sequencer
    import im_pkg::*;
#(
    parameter int ALU_LAT  = 1,
    parameter int FLAG_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [REG_W-1:0]  in_dst,
    input  logic [REG_W-1:0]  in_srca,
    input  logic [REG_W-1:0]  in_srcb,
    input  logic [DATA_W-1:0] in_imm,
    output logic              RD,
    output logic              WR,
    output logic [REG_W-1:0]  RDsel,
    output logic [REG_W-1:0]  WRsel,
    output logic              LD_en,
    output logic              C_en,
    output logic              F_en,
    output logic [DATA_W-1:0] Load_reg,
    output logic              a_cap,
    output logic              b_cap,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(ALU_LAT - 1);
    localparam logic [REG_W-1:0] FLAG_IDX = REG_W'(FLAG_REG);

    // FSM state and instruction fields captured at accept
    state_e              state_r;
    state_e              state_nx_s;
    logic [OP_W-1:0]     op_r,   op_nx_s;
    logic [REG_W-1:0]    dst_r,  dst_nx_s;
    logic [REG_W-1:0]    srca_r, srca_nx_s;
    logic [REG_W-1:0]    srcb_r, srcb_nx_s;
    logic [DATA_W-1:0]   imm_r,  imm_nx_s;
    logic [CNT_W-1:0]    cnt_r,  cnt_nx_s;
    logic [CNT_W-1:0]    cnt_dec_s;

    // Next-cycle output values, registered below
    logic                ready_s, rd_s, wr_s, ld_s, c_s, f_s;
    logic                acap_s, bcap_s, done_s, err_s;
    logic [REG_W-1:0]    rdsel_s, wrsel_s;
    logic [DATA_W-1:0]   load_s;

    logic                ready_r, rd_r, wr_r, ld_r, c_r, f_r;
    logic                acap_r, bcap_r, done_r, err_r;
    logic [REG_W-1:0]    rdsel_r, wrsel_r;
    logic [DATA_W-1:0]   load_r;

    assign cnt_dec_s = cnt_r - 3'd1;

    // Next-state, field capture and latency counter logic
    always_comb begin
        state_nx_s = state_r;
        op_nx_s    = op_r;
        dst_nx_s   = dst_r;
        srca_nx_s  = srca_r;
        srcb_nx_s  = srcb_r;
        imm_nx_s   = imm_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    op_nx_s    = in_op;
                    dst_nx_s   = in_dst;
                    srca_nx_s  = in_srca;
                    srcb_nx_s  = in_srcb;
                    imm_nx_s   = in_imm;
                    state_nx_s = op_to_state(in_op);
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LDI:  state_nx_s = ST_IDLE;
            ST_MOV:  state_nx_s = ST_IDLE;
            ST_NOPX: state_nx_s = ST_IDLE;
            ST_WRF:  state_nx_s = ST_IDLE;
            ST_RDA:  state_nx_s = ST_RDB;
            ST_RDB: begin
                if (ALU_LAT == 1) begin
                    state_nx_s = ST_WRC;
                end else begin
                    state_nx_s = ST_WAIT;
                    cnt_nx_s   = LAT_M1;
                end
            end
            ST_WAIT: begin
                cnt_nx_s = cnt_dec_s;
                if (cnt_dec_s == 3'd0) begin
                    state_nx_s = ST_WRC;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_WRC: begin
                if (op_r == OP_ALUF) begin
                    state_nx_s = ST_WRF;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode for the state about to be entered; one bus driver max
    always_comb begin
        ready_s = 1'b0;
        rd_s    = 1'b0;
        wr_s    = 1'b0;
        ld_s    = 1'b0;
        c_s     = 1'b0;
        f_s     = 1'b0;
        acap_s  = 1'b0;
        bcap_s  = 1'b0;
        done_s  = 1'b0;
        err_s   = 1'b0;
        rdsel_s = 5'd0;
        wrsel_s = 5'd0;
        load_s  = 8'd0;
        case (state_nx_s)
            ST_IDLE: ready_s = 1'b1;
            ST_LDI: begin
                ld_s    = 1'b1;
                wr_s    = 1'b1;
                wrsel_s = dst_nx_s;
                load_s  = imm_nx_s;
                done_s  = 1'b1;
            end
            ST_MOV: begin
                rd_s    = 1'b1;
                rdsel_s = srca_nx_s;
                wr_s    = 1'b1;
                wrsel_s = dst_nx_s;
                done_s  = 1'b1;
            end
            ST_RDA: begin
                rd_s    = 1'b1;
                rdsel_s = srca_nx_s;
                acap_s  = 1'b1;
            end
            ST_RDB: begin
                rd_s    = 1'b1;
                rdsel_s = srcb_nx_s;
                bcap_s  = 1'b1;
            end
            ST_WAIT: ready_s = 1'b0;
            ST_WRC: begin
                c_s     = 1'b1;
                wr_s    = 1'b1;
                wrsel_s = dst_nx_s;
                done_s  = (op_nx_s != OP_ALUF);
            end
            ST_WRF: begin
                f_s     = 1'b1;
                wr_s    = 1'b1;
                wrsel_s = FLAG_IDX;
                done_s  = 1'b1;
            end
            ST_NOPX: begin
                done_s  = 1'b1;
                err_s   = is_illegal_op(op_nx_s);
            end
            default: ready_s = 1'b0;
        endcase
    end

    // State, captured fields and registered outputs; reset drops any
    // in-flight instruction without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= 3'd0;
            dst_r   <= 5'd0;
            srca_r  <= 5'd0;
            srcb_r  <= 5'd0;
            imm_r   <= 8'd0;
            cnt_r   <= 3'd0;
            ready_r <= 1'b1;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            ld_r    <= 1'b0;
            c_r     <= 1'b0;
            f_r     <= 1'b0;
            acap_r  <= 1'b0;
            bcap_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            rdsel_r <= 5'd0;
            wrsel_r <= 5'd0;
            load_r  <= 8'd0;
        end else begin
            state_r <= state_nx_s;
            op_r    <= op_nx_s;
            dst_r   <= dst_nx_s;
            srca_r  <= srca_nx_s;
            srcb_r  <= srcb_nx_s;
            imm_r   <= imm_nx_s;
            cnt_r   <= cnt_nx_s;
            ready_r <= ready_s;
            rd_r    <= rd_s;
            wr_r    <= wr_s;
            ld_r    <= ld_s;
            c_r     <= c_s;
            f_r     <= f_s;
            acap_r  <= acap_s;
            bcap_r  <= bcap_s;
            done_r  <= done_s;
            err_r   <= err_s;
            rdsel_r <= rdsel_s;
            wrsel_r <= wrsel_s;
            load_r  <= load_s;
        end
    end

    assign in_ready = ready_r;
    assign RD       = rd_r;
    assign WR       = wr_r;
    assign RDsel    = rdsel_r;
    assign WRsel    = wrsel_r;
    assign LD_en    = ld_r;
    assign C_en     = c_r;
    assign F_en     = f_r;
    assign Load_reg = load_r;
    assign a_cap    = acap_r;
    assign b_cap    = bcap_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_im_sequencer.sv
// Directed bench for im_sequencer: a main instance (ALU_LAT=2) wired to a
// small IM/ALU model, and a second instance (ALU_LAT=1) for the flag path.
module tb_im_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance signals
    logic       m_valid, m_ready;
    logic [2:0] m_op;
    logic [4:0] m_dst, m_srca, m_srcb;
    logic [7:0] m_imm;
    logic       m_RD, m_WR, m_LD_en, m_C_en, m_F_en, m_a_cap, m_b_cap, m_done, m_err;
    logic [4:0] m_RDsel, m_WRsel;
    logic [7:0] m_Load_reg;

    // second instance signals
    logic       s_valid, s_ready;
    logic [2:0] s_op;
    logic [4:0] s_dst, s_srca, s_srcb;
    logic [7:0] s_imm;
    logic       s_RD, s_WR, s_LD_en, s_C_en, s_F_en, s_a_cap, s_b_cap, s_done, s_err;
    logic [4:0] s_RDsel, s_WRsel;
    logic [7:0] s_Load_reg;

    im_sequencer #(.ALU_LAT(2), .FLAG_REG(31)) dut_m (
        .clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(m_ready),
        .in_op(m_op), .in_dst(m_dst), .in_srca(m_srca), .in_srcb(m_srcb), .in_imm(m_imm),
        .RD(m_RD), .WR(m_WR), .RDsel(m_RDsel), .WRsel(m_WRsel),
        .LD_en(m_LD_en), .C_en(m_C_en), .F_en(m_F_en), .Load_reg(m_Load_reg),
        .a_cap(m_a_cap), .b_cap(m_b_cap), .done(m_done), .err(m_err)
    );

    im_sequencer #(.ALU_LAT(1), .FLAG_REG(31)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready),
        .in_op(s_op), .in_dst(s_dst), .in_srca(s_srca), .in_srcb(s_srcb), .in_imm(s_imm),
        .RD(s_RD), .WR(s_WR), .RDsel(s_RDsel), .WRsel(s_WRsel),
        .LD_en(s_LD_en), .C_en(s_C_en), .F_en(s_F_en), .Load_reg(s_Load_reg),
        .a_cap(s_a_cap), .b_cap(s_b_cap), .done(s_done), .err(s_err)
    );

    logic [31:0] obs_m, obs_s;
    assign obs_m = {4'd0, m_ready, m_RD, m_WR, m_RDsel, m_WRsel, m_LD_en, m_C_en, m_F_en,
                    m_Load_reg, m_a_cap, m_b_cap, m_done, m_err};
    assign obs_s = {4'd0, s_ready, s_RD, s_WR, s_RDsel, s_WRsel, s_LD_en, s_C_en, s_F_en,
                    s_Load_reg, s_a_cap, s_b_cap, s_done, s_err};

    // IM register file + ALU model driven by the main instance's strobes
    logic [7:0] im [32];
    logic [7:0] a_r, b_r, bus_m;
    logic [8:0] sum_s;
    assign sum_s = {1'b0, a_r} + {1'b0, b_r};

    // databus mux from whichever driver is enabled
    always_comb begin
        bus_m = 8'd0;
        if (m_LD_en)     bus_m = m_Load_reg;
        else if (m_RD)   bus_m = im[m_RDsel];
        else if (m_C_en) bus_m = sum_s[7:0];
        else if (m_F_en) bus_m = {7'd0, sum_s[8]};
        else             bus_m = 8'd0;
    end

    // register file writes and operand latches
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) im[i] <= 8'(i + 16);
            a_r <= 8'd0;
            b_r <= 8'd0;
        end else begin
            if (m_WR)    im[m_WRsel] <= bus_m;
            if (m_a_cap) a_r <= bus_m;
            if (m_b_cap) b_r <= bus_m;
        end
    end

    // count cycles with more than one databus driver on either instance
    int bus_viol = 0;
    always @(negedge clk) begin
        if ((int'(m_RD) + int'(m_LD_en) + int'(m_C_en) + int'(m_F_en)) > 1) bus_viol++;
        if ((int'(s_RD) + int'(s_LD_en) + int'(s_C_en) + int'(s_F_en)) > 1) bus_viol++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // expected output vector, same packing as obs_m/obs_s
    function automatic logic [31:0] ev(input logic rdy, input logic rd, input logic wr,
                                       input logic [4:0] rs, input logic [4:0] ws,
                                       input logic ld, input logic c, input logic f,
                                       input logic [7:0] lr, input logic ac, input logic bc,
                                       input logic dn, input logic er);
        return {4'd0, rdy, rd, wr, rs, ws, ld, c, f, lr, ac, bc, dn, er};
    endfunction

    function automatic logic [31:0] idle_v();
        return ev(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [31:0] quiet_v();
        return ev(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // offer one instruction to the main instance; returns in first bus cycle
    task automatic m_issue(input logic [2:0] op, input logic [4:0] dst, input logic [4:0] a,
                           input logic [4:0] b, input logic [7:0] imm);
        m_valid = 1'b1; m_op = op; m_dst = dst; m_srca = a; m_srcb = b; m_imm = imm;
        tick();
        m_valid = 1'b0;
    endtask

    task automatic s_issue(input logic [2:0] op, input logic [4:0] dst, input logic [4:0] a,
                           input logic [4:0] b, input logic [7:0] imm);
        s_valid = 1'b1; s_op = op; s_dst = dst; s_srca = a; s_srcb = b; s_imm = imm;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        m_valid = 1'b0; m_op = 3'd0; m_dst = 5'd0; m_srca = 5'd0; m_srcb = 5'd0; m_imm = 8'd0;
        s_valid = 1'b0; s_op = 3'd0; s_dst = 5'd0; s_srca = 5'd0; s_srcb = 5'd0; s_imm = 8'd0;
        rst = 1'b1;
        tick();
        tick();
        check("reset_m", obs_m, idle_v());
        check("reset_s", obs_s, idle_v());
        rst = 1'b0;

        // LDI dst=7 imm=A5
        m_issue(3'd1, 5'd7, 5'd0, 5'd0, 8'hA5);
        check("ldi", obs_m, ev(1'b0, 1'b0, 1'b1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        check("ldi_idle", obs_m, idle_v());
        check("im7", {24'd0, im[7]}, 32'h0000_00A5);

        // MOV 7 -> 12
        m_issue(3'd2, 5'd12, 5'd7, 5'd0, 8'h00);
        check("mov", obs_m, ev(1'b0, 1'b1, 1'b1, 5'd7, 5'd12, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        check("mov_idle", obs_m, idle_v());
        check("im12", {24'd0, im[12]}, 32'h0000_00A5);

        // MOV with src == dst
        m_issue(3'd2, 5'd12, 5'd12, 5'd0, 8'h00);
        check("mov_same", obs_m, ev(1'b0, 1'b1, 1'b1, 5'd12, 5'd12, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();

        // ALU 3+4 -> 5, latency 2: RDA, RDB, WAIT, WRC
        m_issue(3'd3, 5'd5, 5'd3, 5'd4, 8'h00);
        check("alu_rda", obs_m, ev(1'b0, 1'b1, 1'b0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        check("alu_rdb", obs_m, ev(1'b0, 1'b1, 1'b0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        check("alu_wait", obs_m, quiet_v());
        tick();
        check("alu_wrc", obs_m, ev(1'b0, 1'b0, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        check("alu_idle", obs_m, idle_v());
        check("im5", {24'd0, im[5]}, 32'h0000_0027);

        // ALU 1+2 -> 9 while a conflicting LDI is offered during RDA/RDB
        m_issue(3'd3, 5'd9, 5'd1, 5'd2, 8'h00);
        m_valid = 1'b1; m_op = 3'd1; m_dst = 5'd3; m_imm = 8'hFF;
        check("busy_rda", obs_m, ev(1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        check("busy_rdb", obs_m, ev(1'b0, 1'b1, 1'b0, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        m_valid = 1'b0;
        tick();
        check("busy_wait", obs_m, quiet_v());
        tick();
        check("busy_wrc", obs_m, ev(1'b0, 1'b0, 1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        check("busy_idle", obs_m, idle_v());
        check("im9", {24'd0, im[9]}, 32'h0000_0023);
        check("im3_kept", {24'd0, im[3]}, 32'h0000_0013);

        // illegal and NOP opcodes
        m_issue(3'd6, 5'd1, 5'd2, 5'd3, 8'h55);
        check("op6", obs_m, ev(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
        tick();
        check("op6_idle", obs_m, idle_v());
        m_issue(3'd0, 5'd1, 5'd2, 5'd3, 8'h55);
        check("op0", obs_m, ev(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        m_issue(3'd5, 5'd1, 5'd2, 5'd3, 8'h55);
        check("op5", obs_m, ev(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
        tick();
        m_issue(3'd7, 5'd1, 5'd2, 5'd3, 8'h55);
        check("op7", obs_m, ev(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
        tick();

        // reset wins over a simultaneous accept
        rst = 1'b1; m_valid = 1'b1; m_op = 3'd1; m_dst = 5'd1; m_imm = 8'h11;
        tick();
        rst = 1'b0; m_valid = 1'b0;
        check("rst_prio", obs_m, idle_v());
        tick();
        check("rst_prio_next", obs_m, idle_v());

        // reset during WAIT drops the instruction
        m_issue(3'd3, 5'd5, 5'd3, 5'd4, 8'h00);
        tick();
        tick();
        check("rstw_wait", obs_m, quiet_v());
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_idle", obs_m, idle_v());
        tick();
        check("rstw_nodone", obs_m, idle_v());
        m_issue(3'd1, 5'd20, 5'd0, 5'd0, 8'h3C);
        check("rstw_ldi", obs_m, ev(1'b0, 1'b0, 1'b1, 5'd0, 5'd20, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        check("rstw_im20", {24'd0, im[20]}, 32'h0000_003C);

        // second instance, latency 1: ALUF then ALU
        s_issue(3'd4, 5'd2, 5'd1, 5'd2, 8'h00);
        check("aluf_rda", obs_s, ev(1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        check("aluf_rdb", obs_s, ev(1'b0, 1'b1, 1'b0, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        check("aluf_wrc", obs_s, ev(1'b0, 1'b0, 1'b1, 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        check("aluf_wrf", obs_s, ev(1'b0, 1'b0, 1'b1, 5'd0, 5'd31, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        check("aluf_idle", obs_s, idle_v());
        s_issue(3'd3, 5'd6, 5'd7, 5'd8, 8'h00);
        check("alu1_rda", obs_s, ev(1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        check("alu1_rdb", obs_s, ev(1'b0, 1'b1, 1'b0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        check("alu1_wrc", obs_s, ev(1'b0, 1'b0, 1'b1, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        check("alu1_idle", obs_s, idle_v());

        check("bus_onehot", 32'(bus_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
